// File: rtl/poly_trunc_div_8bit.sv
// rtl/poly_trunc_div_8bit.sv - bit-serial inverse of the truncated carry-less multiplier
module poly_trunc_div_8bit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] b,
  output logic         err
);

  localparam int KW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [KW-1:0] k;
  logic [W-1:0]  a_r, y_r;
  logic [W-1:0]  a_hi, fb, sel;
  logic          nb, last;

  assign a_hi = {a_r[W-1:1], 1'b0};
  assign last = (k == KW'(W - 1));

  // Bits of b at or above k are still zero, so the full carry-less product of
  // the partial b with a (minus its constant term) gives exactly the feedback sum at bit k.
  always_comb begin
    fb = '0;
    for (int j = 0; j < W; j++) begin
      if (b[j]) fb = fb ^ (a_hi << j);
    end
    sel = (y_r ^ fb) >> k;
    nb  = sel[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = a[0] ? RUN : DONE;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      y_r <= '0;
      b   <= '0;
      err <= 1'b0;
      k   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            y_r <= y;
            b   <= '0;
            err <= ~a[0];
            k   <= '0;
          end
        end
        RUN: begin
          b <= b | (W'(nb) << k);
          k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_trunc_div_8bit.sv
// tb/tb_poly_trunc_div_8bit.sv - directed and randomized checks for poly_trunc_div_8bit
module tb_poly_trunc_div_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] b;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rb;
  logic         re;
  int           rl;

  poly_trunc_div_8bit #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) if (z[i]) p = p ^ (x << i);
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, wait for the result, hold it for `stall` cycles
  // (optionally poking in_valid with other data), then hand it off.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] yv, input int stall,
                        input bit poke, output logic [W-1:0] bo, output logic eo,
                        output int lat);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a = av;
    y = yv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    y = W'($urandom);
    lat = 0;
    while (lat <= 40) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    bo = b;
    eo = err;
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = 1'b1;
        a = 8'h01;
        y = 8'h11;
      end
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_b_stable", b, bo);
      check("stall_err_stable", err, eo);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("after_handoff_out_valid", out_valid, 0);
    check("after_handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    y         = '0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_b", b, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;

    run_op(8'h01, 8'h5A, 0, 1'b0, rb, re, rl);
    check("a01_b", rb, 8'h5A);
    check("a01_err", re, 0);
    check("a01_latency", rl, W);

    run_op(8'h03, 8'hFF, 1, 1'b0, rb, re, rl);
    check("a03_b", rb, 8'h55);
    check("a03_err", re, 0);

    run_op(8'hFF, 8'h01, 0, 1'b0, rb, re, rl);
    check("aff_b", rb, 8'h03);
    check("aff_err", re, 0);

    run_op(8'h02, 8'h7E, 0, 1'b0, rb, re, rl);
    check("even_a_err", re, 1);
    check("even_a_b", rb, 8'h00);
    check("even_a_latency", rl, 0);
    @(negedge clk);
    check("idle_holds_err", err, 1);

    run_op(8'h03, 8'hFF, 5, 1'b1, rb, re, rl);
    check("bp_b", rb, 8'h55);
    check("bp_err", re, 0);
    check("bp_b_after", b, 8'h55);

    // Reset in the middle of RUN, once some bits of b are already written
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h03;
    y = 8'hFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrun_in_ready", in_ready, 0);
    check("midrun_partial_b", b, 8'h05);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_b", b, 0);
    check("midrun_rst_err", err, 0);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'hA5, 0, 1'b0, rb, re, rl);
    check("post_reset_b", rb, 8'hA5);
    check("post_reset_err", re, 0);

    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rbv;
      ra  = W'($urandom) | 8'h01;
      rbv = W'($urandom);
      run_op(ra, clmul(ra, rbv), int'($urandom_range(0, 3)), 1'b0, rb, re, rl);
      check("rand_b", rb, rbv);
      check("rand_err", re, 0);
      check("rand_latency", rl, W);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
